// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl -- stall/flush control for a 5-stage in-order pipeline.
//
// Detects load-use hazards, squashes the fetched instruction on a taken
// branch, and holds the front end while a multi-cycle mul/div op is in EX.
//
// Ports:
//   Clock, Reset_n          single clock, asynchronous active-low reset
//   ID_EX_MemRead           EX instruction is a load
//   ID_EX_RegisterRt        load destination register in EX
//   IF_ID_RegisterRs/Rt     source registers of the ID instruction
//   ID_Uses_Rt              ID instruction reads Rt
//   Branch_Taken            branch resolved taken in ID
//   MD_Start                ID instruction is a multi-cycle mul/div
//   PC_Write, IF_ID_Write   front-end enables
//   IF_ID_Flush             zero IF/ID on next edge
//   ID_EX_Flush             insert bubble into ID/EX on next edge
//   Busy                    high while waiting on a mul/div op
//   Stall_Count             (HAZARD_STATS_EN only) saturating count of stall cycles
//
// Optional feature macro: HAZARD_STATS_EN adds the Stall_Count output.
module pipeline_hazard_ctrl #(
    parameter int unsigned rwidth = 5,
    parameter int unsigned MD_LAT = 4   // legal range 2..15
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              ID_EX_MemRead,
    input  logic [rwidth-1:0] ID_EX_RegisterRt,
    input  logic [rwidth-1:0] IF_ID_RegisterRs,
    input  logic [rwidth-1:0] IF_ID_RegisterRt,
    input  logic              ID_Uses_Rt,
    input  logic              Branch_Taken,
    input  logic              MD_Start,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
`ifdef HAZARD_STATS_EN
    output logic              Busy,
    output logic [15:0]       Stall_Count
`else
    output logic              Busy
`endif
);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    // The MD op occupies EX in the RUN cycle that launches it, so the wait
    // lasts MD_LAT-1 cycles: counting MD_LAT-2 down to 0 inclusive.
    localparam logic [3:0] MdInit = 4'(MD_LAT - 2);

    state_e     state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       load_hazard;
    logic       stall;

    assign load_hazard = ID_EX_MemRead && (ID_EX_RegisterRt != '0) &&
                         ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                          (ID_Uses_Rt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall       = 1'b0;
        IF_ID_Flush = 1'b0;
        Busy        = 1'b0;
        unique case (state_q)
            StRun: begin
                // Priority: load hazard, then taken branch, then MD launch.
                if (load_hazard) begin
                    stall = 1'b1;
                end else if (Branch_Taken) begin
                    IF_ID_Flush = 1'b1;
                end else if (MD_Start) begin
                    state_d  = StMdWait;
                    md_cnt_d = MdInit;
                end
            end
            StMdWait: begin
                stall = 1'b1;
                Busy  = 1'b1;
                if (md_cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = StRun;
                md_cnt_d = 4'd0;
            end
        endcase
        PC_Write    = !stall;
        IF_ID_Write = !stall;
        ID_EX_Flush = stall;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StRun;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt_q <= 16'd0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RW     = 5;
    localparam int unsigned MD_LAT = 4;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          ID_EX_MemRead;
    logic [RW-1:0] ID_EX_RegisterRt;
    logic [RW-1:0] IF_ID_RegisterRs;
    logic [RW-1:0] IF_ID_RegisterRt;
    logic          ID_Uses_Rt;
    logic          Branch_Taken;
    logic          MD_Start;
    logic          PC_Write;
    logic          IF_ID_Write;
    logic          IF_ID_Flush;
    logic          ID_EX_Flush;
    logic          Busy;
`ifdef HAZARD_STATS_EN
    logic [15:0]   Stall_Count;
`endif

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(
        .rwidth (RW),
        .MD_LAT (MD_LAT)
    ) dut (
        .Clock            (Clock),
        .Reset_n          (Reset_n),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .ID_Uses_Rt       (ID_Uses_Rt),
        .Branch_Taken     (Branch_Taken),
        .MD_Start         (MD_Start),
        .PC_Write         (PC_Write),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Flush      (ID_EX_Flush),
`ifdef HAZARD_STATS_EN
        .Busy             (Busy),
        .Stall_Count      (Stall_Count)
`else
        .Busy             (Busy)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic          mr;
        logic [RW-1:0] exrt;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          uses_rt;
        logic          br;
        logic          md;
        logic [3:0]    exp;  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [RW-1:0] exrt, input logic [RW-1:0] rs,
                         input logic [RW-1:0] rt, input logic u, input logic br, input logic md);
        ID_EX_MemRead    = mr;
        ID_EX_RegisterRt = exrt;
        IF_ID_RegisterRs = rs;
        IF_ID_RegisterRt = rt;
        ID_Uses_Rt       = u;
        Branch_Taken     = br;
        MD_Start         = md;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 time units later.
    task automatic next_cycle();
        @(negedge Clock);
    endtask

    task automatic do_reset();
        next_cycle();
        Reset_n = 1'b0;
        idle();
        next_cycle();
        Reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic mr, input int exrt, input int rs, input int rt,
                                input logic u, input logic br, input logic md,
                                input logic [3:0] exp);
        vec_t v;
        v.mr = mr; v.exrt = RW'(exrt); v.rs = RW'(rs); v.rt = RW'(rt);
        v.uses_rt = u; v.br = br; v.md = md; v.exp = exp;
        return v;
    endfunction

    // Behavioural reference: remaining wait cycles of the MD op plus a stall tally.
    int          rem;
    int unsigned cnt_m;

    initial begin : main
        logic       lh;
        logic [4:0] exp_o;
        logic [7:0] pat;
        int         busy_cycles;
        bit         pc_ok;

        Reset_n = 1'b0;
        idle();
        #2;
        check("reset_outputs", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Busy}, 5'b11000);
`ifdef HAZARD_STATS_EN
        check("reset_stall_count", Stall_Count, 0);
`endif
        // Outputs during reset follow the RUN decode of the current inputs.
        drive(1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_mealy_lh", {PC_Write, ID_EX_Flush, Busy}, 3'b010);
        next_cycle();
        Reset_n = 1'b1;
        idle();

        // ---------------- table-driven single-cycle decode in RUN ----------------
        vecs[0] = mk(1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0, 4'b0001);
        vecs[1] = mk(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 4'b1100);
        vecs[2] = mk(1'b1, 7, 3, 7, 1'b1, 1'b0, 1'b0, 4'b0001);
        vecs[3] = mk(1'b1, 7, 3, 7, 1'b0, 1'b0, 1'b0, 4'b1100);
        vecs[4] = mk(1'b0, 5, 5, 5, 1'b1, 1'b0, 1'b0, 4'b1100);
        vecs[5] = mk(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 4'b1110);
        vecs[6] = mk(1'b1, 9, 9, 0, 1'b0, 1'b1, 1'b0, 4'b0001);
        vecs[7] = mk(1'b1, 9, 9, 0, 1'b0, 1'b1, 1'b1, 4'b0001);
        vecs[8] = mk(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 4'b1110);
        vecs[9] = mk(1'b1, 31, 2, 31, 1'b1, 1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive(vecs[i].mr, vecs[i].exrt, vecs[i].rs, vecs[i].rt, vecs[i].uses_rt,
                  vecs[i].br, vecs[i].md);
            #2;
            check($sformatf("vec%0d", i), {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Busy},
                  {vecs[i].exp, 1'b0});
        end

        // ---------------- load stall then release ----------------
        next_cycle();
        drive(1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0);
        #2;
        check("ld_stall", {PC_Write, IF_ID_Write, ID_EX_Flush}, 3'b001);
        next_cycle();
        idle();
        #2;
        check("ld_release", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, 4'b1100);

        // ---------------- MD op: exactly MD_LAT-1 stall cycles ----------------
        next_cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        #2;
        check("md_launch", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Busy}, 5'b11000);
        busy_cycles = 0;
        pc_ok = 1'b1;
        next_cycle();
        idle();
        #2;
        while (Busy === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            if (PC_Write !== 1'b0 || ID_EX_Flush !== 1'b1 || IF_ID_Flush !== 1'b0) pc_ok = 1'b0;
            next_cycle();
            #2;
        end
        check("md_busy_len", busy_cycles, MD_LAT - 1);
        check("md_busy_outputs", pc_ok, 1);
        check("md_after", {PC_Write, Busy}, 2'b10);

        // ---------------- back-to-back MD ops: no gap cycle ----------------
        pat = '0;
        next_cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            #2;
            pat[7-i] = Busy;
            next_cycle();
        end
        idle();
        check("md_back_to_back", pat, 8'b01110111);

        // ---------------- reset mid-wait ----------------
        do_reset();
        next_cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        idle();                 // wait cycle 1
        next_cycle();           // wait cycle 2
        #2;
        check("mid_wait_busy", Busy, 1);
        Reset_n = 1'b0;
        #1;
        check("mid_reset_busy", {Busy, PC_Write}, 2'b01);
`ifdef HAZARD_STATS_EN
        check("mid_reset_stall_count", Stall_Count, 0);
`endif
        next_cycle();
        Reset_n = 1'b1;
        #2;
        check("post_reset_run", {Busy, PC_Write}, 2'b01);
        next_cycle();
        #2;
        check("post_reset_run2", {Busy, PC_Write}, 2'b01);

        // ---------------- randomized vs reference model ----------------
        do_reset();
        rem   = 0;
        cnt_m = 0;
        for (int n = 0; n < 2000; n++) begin
            next_cycle();
            Reset_n = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 1) == 1, RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            #2;
            if (!Reset_n) begin
                rem   = 0;
                cnt_m = 0;
            end
            lh = ID_EX_MemRead && ID_EX_RegisterRt != 0 &&
                 (ID_EX_RegisterRt == IF_ID_RegisterRs ||
                  (ID_Uses_Rt && ID_EX_RegisterRt == IF_ID_RegisterRt));
            if (rem > 0)          exp_o = 5'b00011;
            else if (lh)          exp_o = 5'b00010;
            else if (Branch_Taken) exp_o = 5'b11100;
            else                  exp_o = 5'b11000;
            check($sformatf("rand%0d", n),
                  {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Busy}, exp_o);
`ifdef HAZARD_STATS_EN
            check($sformatf("rand_cnt%0d", n), Stall_Count, cnt_m);
`endif
            if (Reset_n) begin
                if (!exp_o[4] && cnt_m < 65535) cnt_m++;
                if (rem > 0) rem--;
                else if (!lh && !Branch_Taken && MD_Start) rem = MD_LAT - 1;
            end
        end
        next_cycle();
        Reset_n = 1'b1;
        idle();

`ifdef HAZARD_STATS_EN
        // ---------------- stall statistics ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b1, 4, 4, 0, 1'b0, 1'b0, 1'b0);
            next_cycle();
            idle();
        end
        next_cycle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        idle();
        for (int i = 0; i < 6; i++) next_cycle();
        #2;
        check("stats_six", Stall_Count, 6);
        drive(1'b1, 4, 4, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) next_cycle();
        #2;
        check("stats_saturate", Stall_Count, 16'hFFFF);
        next_cycle();
        #2;
        check("stats_hold", Stall_Count, 16'hFFFF);
        idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
